// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch in front of the control unit.
//   Holds the PC and reads 16-bit words from instruction memory over a
//   req/ack handshake. IADD and LDM take a second word as the immediate.
//   The fetched instruction is presented to decode with a valid/ready
//   handshake. Fetch stops after an accepted HLT until reset or redirect.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   imem_req/addr           read request and address (the current PC)
//   imem_ack/rdata          read data valid and instruction word
//   redirect_en/pc          load a new PC and flush whatever is in progress
//   out_valid/out_ready     handshake towards decode
//   opcode, instr, imm      presented instruction (opcode = instr[15:9])
//   pc_out                  address of the first word of the instruction
//   halted                  fetch stopped after HLT
module fetch_stage #(
    parameter int             AW       = 16,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter logic [6:0]     OPC_IADD = 7'b0100000,
    parameter logic [6:0]     OPC_LDM  = 7'b0110101,
    parameter logic [6:0]     OPC_HLT  = 7'b1100001
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [15:0]   imem_rdata,
    input  logic          redirect_en,
    input  logic [AW-1:0] redirect_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [6:0]    opcode,
    output logic [15:0]   instr,
    output logic [15:0]   imm,
    output logic [AW-1:0] pc_out,
    output logic          halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_IMM   = 2'd1,
        S_OUT   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   instr_q, instr_d;
    logic [15:0]   imm_q, imm_d;
    logic [AW-1:0] pc_out_q, pc_out_d;

    logic [6:0]    rd_opc;
    logic [AW-1:0] pc_inc;

    assign rd_opc = imem_rdata[15:9];
    // Wraps modulo 2^AW with no carry out.
    assign pc_inc = pc_q + AW'(1);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        imm_d    = imm_q;
        pc_out_d = pc_out_q;

        if (redirect_en) begin
            // Flush: any ack this cycle and any held instruction are dropped;
            // instr/imm keep their old contents.
            pc_d    = redirect_pc;
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        imm_d    = '0;
                        pc_d     = pc_inc;
                        if (rd_opc == OPC_IADD || rd_opc == OPC_LDM)
                            state_d = S_IMM;
                        else
                            state_d = S_OUT;
                    end
                end
                S_IMM: begin
                    if (imem_ack) begin
                        imm_d   = imem_rdata;
                        pc_d    = pc_inc;
                        state_d = S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready)
                        state_d = (instr_q[15:9] == OPC_HLT) ? S_HALT : S_FETCH;
                end
                default: ;  // S_HALT: only reset or redirect leave
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            imm_q    <= '0;
            pc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            imm_q    <= imm_d;
            pc_out_q <= pc_out_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH) || (state_q == S_IMM);
    assign imem_addr = pc_q;
    assign out_valid = (state_q == S_OUT);
    assign halted    = (state_q == S_HALT);
    assign instr     = instr_q;
    assign opcode    = instr_q[15:9];
    assign imm       = imm_q;
    assign pc_out    = pc_out_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // ---- DUT 1: RESET_PC = 0, memory modelled by a small array ----
    logic        reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [15:0] imem_addr, imem_rdata;
    logic        redirect_en = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [6:0]  opcode;
    logic [15:0] instr, imm, pc_out;
    logic        halted;
    logic [15:0] mem [64];

    assign imem_rdata = mem[imem_addr[5:0]];

    fetch_stage #(.AW(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .instr(instr), .imm(imm),
        .pc_out(pc_out), .halted(halted)
    );

    // ---- DUT 2: RESET_PC = 0xFFFF for the wrap / mid-IMM reset case ----
    logic        reset2 = 1'b1;
    logic        req2, ack2 = 1'b1, ov2, hlt2;
    logic [15:0] addr2, rdata2, instr2, imm2, pco2;
    logic [6:0]  opc2;

    assign rdata2 = (addr2 == 16'hFFFF) ? 16'h0200 :
                    (addr2 == 16'h0000) ? 16'h4000 : 16'h00CD;

    fetch_stage #(.AW(16), .RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .reset(reset2),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2),
        .redirect_en(1'b0), .redirect_pc(16'h0000),
        .out_valid(ov2), .out_ready(1'b1),
        .opcode(opc2), .instr(instr2), .imm(imm2),
        .pc_out(pco2), .halted(hlt2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rdir;
        logic [15:0] rpc;
        logic        rdy;
        logic        ack;
        logic        req;
        logic [15:0] addr;
        logic        ov;
        logic [6:0]  opc;
        logic [15:0] imm;
        logic [15:0] pco;
        logic        hlt;
    } vec_t;

    function automatic vec_t mk(logic rdir, logic [15:0] rpc, logic rdy, logic ack,
                                logic req, logic [15:0] addr, logic ov, logic [6:0] opc,
                                logic [15:0] imm_e, logic [15:0] pco, logic hlt);
        vec_t v;
        v.rdir = rdir; v.rpc = rpc; v.rdy = rdy; v.ack = ack;
        v.req = req; v.addr = addr; v.ov = ov; v.opc = opc;
        v.imm = imm_e; v.pco = pco; v.hlt = hlt;
        return v;
    endfunction

    vec_t vt [34];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[0]  = 16'h0200;  // ADD
        mem[1]  = 16'h0402;
        mem[2]  = 16'h0600;
        mem[3]  = 16'h0800;
        mem[4]  = 16'h4000;  // IADD
        mem[5]  = 16'h00AB;
        mem[6]  = 16'h6A00;  // LDM
        mem[7]  = 16'h1234;
        mem[8]  = 16'hC200;  // HLT
        mem[16] = 16'h0200;
        mem[17] = 16'h0A00;
        mem[18] = 16'h7777;
        mem[32] = 16'h4000;
        mem[33] = 16'h9999;

        //        rdir rpc    rdy  ack  | req addr    ov opc      imm      pco      hlt
        vt[0]  = mk(0, 16'h0,  1, 1,   1, 16'h00, 0, 7'h00, 16'h0,    16'h00, 0);
        vt[1]  = mk(0, 16'h0,  1, 1,   0, 16'h01, 1, 7'h01, 16'h0,    16'h00, 0);
        vt[2]  = mk(0, 16'h0,  1, 1,   1, 16'h01, 0, 7'h01, 16'h0,    16'h00, 0);
        vt[3]  = mk(0, 16'h0,  0, 1,   0, 16'h02, 1, 7'h02, 16'h0,    16'h01, 0);
        vt[4]  = mk(0, 16'h0,  0, 1,   0, 16'h02, 1, 7'h02, 16'h0,    16'h01, 0);
        vt[5]  = mk(0, 16'h0,  0, 1,   0, 16'h02, 1, 7'h02, 16'h0,    16'h01, 0);
        vt[6]  = mk(0, 16'h0,  0, 1,   0, 16'h02, 1, 7'h02, 16'h0,    16'h01, 0);
        vt[7]  = mk(0, 16'h0,  0, 1,   0, 16'h02, 1, 7'h02, 16'h0,    16'h01, 0);
        vt[8]  = mk(0, 16'h0,  1, 1,   0, 16'h02, 1, 7'h02, 16'h0,    16'h01, 0);
        vt[9]  = mk(0, 16'h0,  1, 0,   1, 16'h02, 0, 7'h02, 16'h0,    16'h01, 0);
        vt[10] = mk(0, 16'h0,  1, 0,   1, 16'h02, 0, 7'h02, 16'h0,    16'h01, 0);
        vt[11] = mk(0, 16'h0,  1, 1,   1, 16'h02, 0, 7'h02, 16'h0,    16'h01, 0);
        vt[12] = mk(0, 16'h0,  1, 1,   0, 16'h03, 1, 7'h03, 16'h0,    16'h02, 0);
        vt[13] = mk(0, 16'h0,  1, 1,   1, 16'h03, 0, 7'h03, 16'h0,    16'h02, 0);
        vt[14] = mk(0, 16'h0,  1, 1,   0, 16'h04, 1, 7'h04, 16'h0,    16'h03, 0);
        vt[15] = mk(0, 16'h0,  1, 1,   1, 16'h04, 0, 7'h04, 16'h0,    16'h03, 0);
        vt[16] = mk(0, 16'h0,  1, 1,   1, 16'h05, 0, 7'h20, 16'h0,    16'h04, 0);
        vt[17] = mk(0, 16'h0,  1, 1,   0, 16'h06, 1, 7'h20, 16'h00AB, 16'h04, 0);
        vt[18] = mk(0, 16'h0,  1, 1,   1, 16'h06, 0, 7'h20, 16'h00AB, 16'h04, 0);
        vt[19] = mk(0, 16'h0,  1, 1,   1, 16'h07, 0, 7'h35, 16'h0,    16'h06, 0);
        vt[20] = mk(0, 16'h0,  1, 1,   0, 16'h08, 1, 7'h35, 16'h1234, 16'h06, 0);
        vt[21] = mk(0, 16'h0,  1, 1,   1, 16'h08, 0, 7'h35, 16'h1234, 16'h06, 0);
        vt[22] = mk(0, 16'h0,  1, 1,   0, 16'h09, 1, 7'h61, 16'h0,    16'h08, 0);
        vt[23] = mk(0, 16'h0,  1, 1,   0, 16'h09, 0, 7'h61, 16'h0,    16'h08, 1);
        vt[24] = mk(0, 16'h0,  1, 1,   0, 16'h09, 0, 7'h61, 16'h0,    16'h08, 1);
        vt[25] = mk(1, 16'h10, 1, 1,   0, 16'h09, 0, 7'h61, 16'h0,    16'h08, 1);
        vt[26] = mk(0, 16'h0,  1, 1,   1, 16'h10, 0, 7'h61, 16'h0,    16'h08, 0);
        // redirect while an instruction is offered with out_ready=1: dropped
        vt[27] = mk(1, 16'h20, 1, 1,   0, 16'h11, 1, 7'h01, 16'h0,    16'h10, 0);
        vt[28] = mk(0, 16'h0,  1, 1,   1, 16'h20, 0, 7'h01, 16'h0,    16'h10, 0);
        // redirect together with the immediate ack: immediate discarded
        vt[29] = mk(1, 16'h11, 1, 1,   1, 16'h21, 0, 7'h20, 16'h0,    16'h20, 0);
        vt[30] = mk(0, 16'h0,  1, 1,   1, 16'h11, 0, 7'h20, 16'h0,    16'h20, 0);
        vt[31] = mk(0, 16'h0,  1, 1,   0, 16'h12, 1, 7'h05, 16'h0,    16'h11, 0);
        // redirect together with a first-word ack: word ignored
        vt[32] = mk(1, 16'h30, 1, 1,   1, 16'h12, 0, 7'h05, 16'h0,    16'h11, 0);
        vt[33] = mk(0, 16'h0,  1, 0,   1, 16'h30, 0, 7'h05, 16'h0,    16'h11, 0);

        // reset for two edges with ack held high: nothing may be latched
        reset = 1'b1; imem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; imem_ack = 1'b0;
        #1;
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset instr", {16'b0, instr}, 32'd0);
        chk("reset halted", {31'b0, halted}, 32'd0);

        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            redirect_en = vt[i].rdir;
            redirect_pc = vt[i].rpc;
            out_ready   = vt[i].rdy;
            imem_ack    = vt[i].ack;
            #1;
            chk($sformatf("v%0d imem_req", i),  {31'b0, imem_req},  {31'b0, vt[i].req});
            chk($sformatf("v%0d imem_addr", i), {16'b0, imem_addr}, {16'b0, vt[i].addr});
            chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vt[i].ov});
            chk($sformatf("v%0d opcode", i),    {25'b0, opcode},    {25'b0, vt[i].opc});
            chk($sformatf("v%0d imm", i),       {16'b0, imm},       {16'b0, vt[i].imm});
            chk($sformatf("v%0d pc_out", i),    {16'b0, pc_out},    {16'b0, vt[i].pco});
            chk($sformatf("v%0d halted", i),    {31'b0, halted},    {31'b0, vt[i].hlt});
        end
        redirect_en = 1'b0; imem_ack = 1'b0;

        // ---- RESET_PC = 0xFFFF: wrap, then reset in the middle of S_IMM ----
        @(negedge clk);
        reset2 = 1'b0;
        #1;
        chk("w0 addr", {16'b0, addr2}, 32'h0000FFFF);
        chk("w0 req", {31'b0, req2}, 32'd1);
        @(negedge clk);
        #1;
        chk("w1 out_valid", {31'b0, ov2}, 32'd1);
        chk("w1 pc_out", {16'b0, pco2}, 32'h0000FFFF);
        chk("w1 addr wrap", {16'b0, addr2}, 32'h00000000);
        chk("w1 opcode", {25'b0, opc2}, 32'h01);
        @(negedge clk);
        #1;
        chk("w2 req", {31'b0, req2}, 32'd1);
        chk("w2 out_valid", {31'b0, ov2}, 32'd0);
        @(negedge clk);
        #1;
        chk("w3 imm addr", {16'b0, addr2}, 32'h00000001);
        chk("w3 opcode", {25'b0, opc2}, 32'h20);
        chk("w3 pc_out", {16'b0, pco2}, 32'h00000000);
        reset2 = 1'b1;  // ack2 still high: the immediate must be discarded
        @(negedge clk);
        #1;
        chk("w4 addr", {16'b0, addr2}, 32'h0000FFFF);
        chk("w4 out_valid", {31'b0, ov2}, 32'd0);
        chk("w4 imm", {16'b0, imm2}, 32'd0);
        chk("w4 instr", {16'b0, instr2}, 32'd0);
        chk("w4 halted", {31'b0, hlt2}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage sitting directly upstream of the control unit. Maintains the PC and reads 16-bit instruction words from instruction memory over a req/ack handshake. For immediate-carrying opcodes (IADD, LDM) it fetches a second word. It presents opcode, instruction, immediate and PC to decode with a valid/ready handshake, stops fetching after HLT, and accepts PC redirects.

Parameters:
AW, 16, PC / instruction-memory address width
RESET_PC, 0, PC value loaded on reset
OPC_IADD, 7'b0100000, opcode that takes a second (immediate) word
OPC_LDM, 7'b0110101, opcode that takes a second (immediate) word
OPC_HLT, 7'b1100001, opcode that halts fetch

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  read request to instruction memory
imem_addr  output  AW  read address (current PC)
imem_ack  input  1  read data valid; sampled only while imem_req=1
imem_rdata  input  16  instruction word
redirect_en  input  1  load redirect_pc and flush
redirect_pc  input  AW  new PC
out_valid  output  1  fetched instruction available to decode
out_ready  input  1  decode accepts the instruction
opcode  output  7  instr[15:9], drives the control unit opcode input
instr  output  16  first instruction word
imm  output  16  second word for IADD/LDM; 0 otherwise
pc_out  output  AW  address of the first word of the presented instruction
halted  output  1  fetch stopped after HLT

Behaviour:
- Reset: reset=1 at an edge sets PC=RESET_PC, state=S_FETCH, out_valid=0, instr=0, imm=0, pc_out=0, halted=0. Reset overrides everything, including mid-handshake, and any in-flight ack is discarded.
- imem_req and imem_addr are combinational from state and PC. imem_req=1 only in S_FETCH and S_IMM. imem_addr=PC.
- S_FETCH: on imem_ack, latch instr=imem_rdata, pc_out=PC, imm=0, and set PC=PC+1.
  - If imem_rdata[15:9] is OPC_IADD or OPC_LDM, go to S_IMM.
  - Otherwise go to S_OUT.
- S_IMM: on imem_ack, latch imm=imem_rdata, set PC=PC+1, go to S_OUT.
- S_OUT: out_valid=1. Outputs stay stable until out_ready=1.
  - On acceptance with opcode==OPC_HLT, go to S_HALT.
  - On acceptance with any other opcode, go to S_FETCH.
  - No fetch overlap; minimum 2 cycles per one-word instruction and 3 per two-word instruction, given single-cycle ack.
- S_HALT: imem_req=0, out_valid=0, halted=1, PC frozen. Exits only on reset or redirect.
- Redirect:
  - Priority is below reset and above all else, in any state.
  - Next edge: PC=redirect_pc, state=S_FETCH, out_valid=0, halted=0, instr/imm unchanged.
  - An imem_ack in the same cycle is ignored; the memory tolerates req dropping before ack.
  - An instruction held in S_OUT is discarded even if out_ready=1 in that cycle. Decode must not commit it when redirect_en=1.
- PC arithmetic: modulo 2^AW. PC = 2^AW-1 increments to 0 with no flag.
- Wait states: an unbounded number of cycles with imem_ack=0 holds the state; PC and outputs are unchanged.
- opcode is always instr[15:9]. Registered outputs only change at state transitions listed above.

Test Plan:
- Reset, mem word 0x0200 (ADD, opcode 0000001) at addr 0, ack every cycle, out_ready=1 -> cycle 2 out_valid=1, opcode=7'b0000001, pc_out=0, imm=0; next fetch addr=1.
- Addr 4=0x4000 (IADD), addr 5=0x00AB -> out_valid with opcode=7'b0100000, imm=0x00AB, pc_out=4; next imem_addr=6.
- out_ready=0 for 5 cycles during S_OUT -> outputs stable, imem_req=0; accept on cycle 6, then fetch resumes at the next PC.
- Word 0xC200 (HLT) accepted -> halted=1, imem_req=0 indefinitely; redirect_en=1, redirect_pc=0x0010 -> halted=0, imem_addr=0x0010 next cycle.
- redirect_en asserted in the same cycle as imem_ack in S_IMM -> immediate discarded, no out_valid, imem_addr=redirect_pc next cycle.
- RESET_PC=16'hFFFF with a one-word instruction -> pc_out=0xFFFF, next imem_addr=0x0000. Reset asserted mid-S_IMM -> PC=0xFFFF, out_valid=0.
